// File: rtl/mips_ctrl_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control unit:
// FSM states, instruction opcode/funct values and ALU operation codes.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,
    S_DECODE = 4'd1,
    S_MEMADR = 4'd2,
    S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,
    S_MEMWR  = 4'd5,
    S_EXEC   = 4'd6,
    S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,
    S_IEXEC  = 4'd9,
    S_IWB    = 4'd10,
    S_JUMP   = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_SLT = 3'b111;

  // Coarse operation chosen by the FSM; FUNCT defers to the R-type funct field.
  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;
  localparam logic [1:0] AOP_OR    = 2'b11;

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU-control decode from the FSM's coarse ALU op and the
// instruction funct field; 3-bit codes are zero-extended to ALU_CTRL_W.
module mc_alu_decoder
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3
) (
  input  logic [1:0]            i_alu_op,
  input  logic [5:0]            i_funct,
  output logic [ALU_CTRL_W-1:0] o_alu_ctrl
);

  logic [2:0] w_code;

  always_comb begin
    w_code = ALU_ADD;
    case (i_alu_op)
      AOP_ADD: w_code = ALU_ADD;
      AOP_SUB: w_code = ALU_SUB;
      AOP_OR:  w_code = ALU_OR;
      AOP_FUNCT: begin
        // Unknown funct values quietly fall back to add.
        case (i_funct)
          FN_ADD:  w_code = ALU_ADD;
          FN_SUB:  w_code = ALU_SUB;
          FN_AND:  w_code = ALU_AND;
          FN_OR:   w_code = ALU_OR;
          FN_SLT:  w_code = ALU_SLT;
          default: w_code = ALU_ADD;
        endcase
      end
      default: w_code = ALU_ADD;
    endcase
  end

  assign o_alu_ctrl = ALU_CTRL_W'(w_code);

endmodule

// File: rtl/multicycle_controller.sv
// Moore control FSM for the multi-cycle MIPS datapath, sequencing each
// instruction over 2-5 cycles plus memory stalls.
module multicycle_controller
  import mips_ctrl_pkg::*;
#(
  parameter int ALU_CTRL_W = 3,
  parameter bit EN_BNE     = 1'b1,
  parameter bit EN_ORI     = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic [5:0]            i_opcode,
  input  logic [5:0]            i_funct,
  input  logic                  i_zero,
  input  logic                  i_mem_ready,
  output logic                  o_pc_en,
  output logic                  o_iord,
  output logic                  o_mem_we,
  output logic                  o_ir_we,
  output logic                  o_reg_dst,
  output logic                  o_mem2reg,
  output logic                  o_we3,
  output logic                  o_src_a,
  output logic [1:0]            o_src_b,
  output logic                  o_zext,
  output logic [1:0]            o_pc_src,
  output logic [ALU_CTRL_W-1:0] o_alu_ctrl,
  output logic                  o_illegal,
  output logic                  o_retire
);

  state_t r_state;
  state_t w_state_next;
  logic   r_is_bne;

  logic                  w_pcwrite;
  logic                  w_branch;
  logic                  w_bne;
  logic                  w_iord;
  logic                  w_mem_we;
  logic                  w_ir_we;
  logic                  w_reg_dst;
  logic                  w_mem2reg;
  logic                  w_we3;
  logic                  w_src_a;
  logic [1:0]            w_src_b;
  logic                  w_zext;
  logic [1:0]            w_pc_src;
  logic [1:0]            w_alu_op;
  logic                  w_alu_en;
  logic                  w_illegal;
  logic                  w_retire;
  logic [ALU_CTRL_W-1:0] w_alu_ctrl;

  // BRANCH must not look at the opcode, so the beq/bne flavour is latched in DECODE.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state  <= S_FETCH;
      r_is_bne <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (r_state == S_DECODE) begin
        r_is_bne <= EN_BNE && (i_opcode == OP_BNE);
      end
    end
  end

  always_comb begin
    w_state_next = r_state;
    w_pcwrite    = 1'b0;
    w_branch     = 1'b0;
    w_bne        = 1'b0;
    w_iord       = 1'b0;
    w_mem_we     = 1'b0;
    w_ir_we      = 1'b0;
    w_reg_dst    = 1'b0;
    w_mem2reg    = 1'b0;
    w_we3        = 1'b0;
    w_src_a      = 1'b0;
    w_src_b      = 2'b00;
    w_zext       = 1'b0;
    w_pc_src     = 2'b00;
    w_alu_op     = AOP_ADD;
    w_alu_en     = 1'b0;
    w_illegal    = 1'b0;
    w_retire     = 1'b0;

    case (r_state)
      S_FETCH: begin
        w_src_b  = 2'b01;
        w_alu_en = 1'b1;
        if (i_mem_ready) begin
          w_ir_we      = 1'b1;
          w_pcwrite    = 1'b1;
          w_state_next = S_DECODE;
        end
      end
      S_DECODE: begin
        w_src_b  = 2'b11;
        w_alu_en = 1'b1;
        case (i_opcode)
          OP_LW, OP_SW: w_state_next = S_MEMADR;
          OP_RTYPE:     w_state_next = S_EXEC;
          OP_BEQ:       w_state_next = S_BRANCH;
          OP_ADDI:      w_state_next = S_IEXEC;
          OP_J:         w_state_next = S_JUMP;
          OP_BNE: begin
            if (EN_BNE) begin
              w_state_next = S_BRANCH;
            end else begin
              w_state_next = S_FETCH;
              w_illegal    = 1'b1;
            end
          end
          OP_ORI: begin
            if (EN_ORI) begin
              w_state_next = S_IEXEC;
            end else begin
              w_state_next = S_FETCH;
              w_illegal    = 1'b1;
            end
          end
          default: begin
            w_state_next = S_FETCH;
            w_illegal    = 1'b1;
          end
        endcase
      end
      S_MEMADR: begin
        w_src_a      = 1'b1;
        w_src_b      = 2'b10;
        w_alu_en     = 1'b1;
        w_state_next = (i_opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        w_iord = 1'b1;
        if (i_mem_ready) begin
          w_state_next = S_MEMWB;
        end
      end
      S_MEMWR: begin
        w_iord   = 1'b1;
        w_mem_we = 1'b1;
        if (i_mem_ready) begin
          w_retire     = 1'b1;
          w_state_next = S_FETCH;
        end
      end
      S_MEMWB: begin
        w_we3        = 1'b1;
        w_mem2reg    = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_EXEC: begin
        w_src_a      = 1'b1;
        w_alu_op     = AOP_FUNCT;
        w_alu_en     = 1'b1;
        w_state_next = S_ALUWB;
      end
      S_ALUWB: begin
        w_we3        = 1'b1;
        w_reg_dst    = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_BRANCH: begin
        w_src_a      = 1'b1;
        w_alu_op     = AOP_SUB;
        w_alu_en     = 1'b1;
        w_pc_src     = 2'b01;
        w_branch     = !r_is_bne;
        w_bne        = r_is_bne;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_IEXEC: begin
        w_src_a  = 1'b1;
        w_src_b  = 2'b10;
        w_alu_en = 1'b1;
        if (EN_ORI && (i_opcode == OP_ORI)) begin
          w_alu_op = AOP_OR;
          w_zext   = 1'b1;
        end
        w_state_next = S_IWB;
      end
      S_IWB: begin
        w_we3        = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      S_JUMP: begin
        w_pc_src     = 2'b10;
        w_pcwrite    = 1'b1;
        w_retire     = 1'b1;
        w_state_next = S_FETCH;
      end
      default: w_state_next = S_FETCH;
    endcase
  end

  mc_alu_decoder #(
    .ALU_CTRL_W(ALU_CTRL_W)
  ) u_alu_dec (
    .i_alu_op  (w_alu_op),
    .i_funct   (i_funct),
    .o_alu_ctrl(w_alu_ctrl)
  );

  // Reset forces every output low immediately, so an abandoned access never writes.
  assign o_pc_en    = !i_rst && (w_pcwrite || (w_branch && i_zero) || (w_bne && !i_zero));
  assign o_iord     = !i_rst && w_iord;
  assign o_mem_we   = !i_rst && w_mem_we;
  assign o_ir_we    = !i_rst && w_ir_we;
  assign o_reg_dst  = !i_rst && w_reg_dst;
  assign o_mem2reg  = !i_rst && w_mem2reg;
  assign o_we3      = !i_rst && w_we3;
  assign o_src_a    = !i_rst && w_src_a;
  assign o_src_b    = i_rst ? 2'b00 : w_src_b;
  assign o_zext     = !i_rst && w_zext;
  assign o_pc_src   = i_rst ? 2'b00 : w_pc_src;
  assign o_alu_ctrl = (i_rst || !w_alu_en) ? '0 : w_alu_ctrl;
  assign o_illegal  = !i_rst && w_illegal;
  assign o_retire   = !i_rst && w_retire;

endmodule

// File: doc/multicycle_controller.md
# multicycle_controller

Control unit for the multi-cycle MIPS datapath: a registered Moore state machine that sequences each instruction over 3–5 cycles and drives the shared-memory, register-file and ALU select lines. It is the successor to the single-cycle controller. Additions over that block:
- parametrised ALU-control width;
- optional `bne` and `ori` support;
- a memory-ready stall handshake;
- illegal-opcode reporting.

It sits between the instruction register (opcode/funct) and the multi-cycle datapath.

## Interface
Parameters:
- `ALU_CTRL_W`, 3: width of `o_alu_ctrl`. Must be ≥3; codes are zero-extended.
- `EN_BNE`, 1: decode `bne` (opcode 000101).
- `EN_ORI`, 1: decode `ori` (opcode 001101).

Ports:
- `i_clk`  in  1  clock. Single clock domain.
- `i_rst`  in  1  reset. Synchronous, active-high.
- `i_opcode`  in  6  instruction-register opcode.
- `i_funct`  in  6  instruction-register funct.
- `i_zero`  in  1  ALU zero flag.
- `i_mem_ready`  in  1  memory access completes this cycle.
- `o_pc_en`  out  1  PC register load.
- `o_iord`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `o_mem_we`  out  1  memory write.
- `o_ir_we`  out  1  instruction register load.
- `o_reg_dst`  out  1  write register: 1 = rd, 0 = rt.
- `o_mem2reg`  out  1  write data: 1 = memory data register, 0 = ALUOut.
- `o_we3`  out  1  register-file write.
- `o_src_a`  out  1  ALU A: 0 = PC, 1 = register A.
- `o_src_b`  out  2  ALU B: 00 = B, 01 = 4, 10 = sign-extended immediate, 11 = sign-extended immediate << 2.
- `o_zext`  out  1  zero-extend the immediate (`ori`).
- `o_pc_src`  out  2  PC source: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `o_alu_ctrl`  out  `ALU_CTRL_W`  ALU operation.
- `o_illegal`  out  1  one-cycle pulse on an undecoded opcode.
- `o_retire`  out  1  one-cycle pulse when an instruction completes.

## Operation
- States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, IEXEC, IWB, JUMP.
- FETCH:
  - `o_src_a`=0, `o_src_b`=01, ALU add, `o_pc_src`=00, `o_iord`=0.
  - `o_ir_we` and the PC write are asserted only when `i_mem_ready`=1. The state holds until then, then goes to DECODE.
- DECODE: `o_src_a`=0, `o_src_b`=11, add (branch target). Next state by opcode:
  - 100011 / 101011 → MEMADR
  - 000000 → EXEC
  - 000100 → BRANCH
  - 000101 → BRANCH, when `EN_BNE`=1
  - 001000 → IEXEC
  - 001101 → IEXEC, when `EN_ORI`=1
  - 000010 → JUMP
  - anything else → FETCH with `o_illegal`=1
- MEMADR: `o_src_a`=1, `o_src_b`=10, add. Goes to MEMRD (lw) or MEMWR (sw).
- MEMRD: `o_iord`=1. Holds until `i_mem_ready`, then goes to MEMWB.
- MEMWR: `o_iord`=1, `o_mem_we`=1. Holds until `i_mem_ready`, then retires and goes to FETCH. `o_mem_we` stays high for every stalled cycle.
- MEMWB: `o_we3`=1, `o_reg_dst`=0, `o_mem2reg`=1. Retires and goes to FETCH.
- EXEC: `o_src_a`=1, `o_src_b`=00, ALU op from funct. Goes to ALUWB.
- ALUWB: `o_we3`=1, `o_reg_dst`=1, `o_mem2reg`=0. Retires and goes to FETCH.
- BRANCH: `o_src_a`=1, `o_src_b`=00, subtract, `o_pc_src`=01.
  - PC write when `i_zero` (beq) or `!i_zero` (bne).
  - Retires and goes to FETCH.
- IEXEC: `o_src_a`=1, `o_src_b`=10.
  - addi: add.
  - ori: or, with `o_zext`=1.
  - Goes to IWB.
- IWB: `o_we3`=1, `o_reg_dst`=0, `o_mem2reg`=0. Retires and goes to FETCH.
- JUMP: `o_pc_src`=10, PC write. Retires and goes to FETCH.
- `o_pc_en` = pcwrite | (branch & `i_zero`) | (bne & !`i_zero`). This is combinational from state and `i_zero`.
- ALU codes: add 010, sub 110, and 000, or 001, slt 111.
- R-type funct decode:
  - 100000 → add
  - 100010 → sub
  - 100100 → and
  - 100101 → or
  - 101010 → slt
  - any other funct → add, with no illegal flag.
- Select outputs not listed for a state are 0.

## Timing
- The state register updates on the `i_clk` rising edge. All outputs are combinational from the state register, except `o_pc_en` (also uses `i_zero`) and the stall-gated enables (also use `i_mem_ready`).
- Cycles without stalls: R-type 4, lw 5, sw 4, beq/bne 3, addi/ori 4, j 3, illegal 2.
- Each stall cycle adds one cycle. No write enable fires twice for one access.
- Reset:
  - While `i_rst`=1, every output is 0, including all enables and `o_illegal`/`o_retire`.
  - The state is FETCH on the next edge.
  - A reset mid-instruction abandons that instruction with no partial register-file write. A reset during a stalled MEMWR drops `o_mem_we` in the same cycle.
- `i_opcode` is sampled only in DECODE, MEMADR and IEXEC. The instruction register is stable then.

## Structure
- Package `mips_ctrl_pkg`:
  - state enum;
  - opcode and funct localparams;
  - ALU code localparams.
- Sub-module `mc_alu_decoder`: combinational mapping from (alu_op[1:0], funct) to ALU control, parametrised by `ALU_CTRL_W`.
- The top level holds the FSM, output decode and `o_pc_en` logic.

## Test plan
- Reset, then R-type add (funct 100000) with `i_mem_ready`=1 → FETCH, DECODE, EXEC (`o_alu_ctrl`=010), ALUWB (`o_we3`=1, `o_reg_dst`=1), `o_retire` in cycle 4.
- lw with `i_mem_ready` low for 2 cycles in MEMRD → 7 cycles total, a single `o_we3` pulse in MEMWB with `o_mem2reg`=1.
- beq with `i_zero`=1 → `o_pc_en`=1 in BRANCH. With `i_zero`=0 → `o_pc_en`=0.
- bne, both `i_zero` values → `o_pc_en` is the inverse of the beq case. With `EN_BNE`=0 → `o_illegal` pulse, back to FETCH after 2 cycles.
- ori → IEXEC with `o_alu_ctrl`=001, `o_zext`=1, `o_src_b`=10, then IWB `o_we3`=1.
- sw stalled in MEMWR, with `i_rst` asserted in the second stall cycle → `o_mem_we`=0 that cycle, state FETCH after the edge.
